// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared FSM encoding, B3/S23 rule constants and grid index helper
package life_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fsm_t;

  localparam logic [3:0] BIRTH_N    = 4'd3;
  localparam logic [3:0] SURVIVE_LO = 4'd2;
  localparam logic [3:0] SURVIVE_HI = 4'd3;

  // Flat bit position of cell (r,c); bit 0 is the top-left cell.
  function automatic int idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/life_cell.sv
// rtl/life_cell.sv - one Game of Life cell: 8 neighbour bits plus own bit to next bit
module life_cell
  import life_pkg::*;
(
  input  logic [7:0] nbr,
  input  logic       own,
  output logic       next
);

  logic [3:0] cnt;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, nbr[i]};
    end
  end

  assign next = own ? ((cnt >= SURVIVE_LO) && (cnt <= SURVIVE_HI)) : (cnt == BIRTH_N);

endmodule

// File: rtl/life_grid_engine.sv
// rtl/life_grid_engine.sv - parametrised Game of Life engine with load/step/run control
// Optional period-2 oscillator detection is built when LIFE_OSC_DETECT_EN is defined.
module life_grid_engine
  import life_pkg::*;
#(
  parameter int ROWS           = 10,
  parameter int COLS           = 10,
  parameter int WRAP           = 0,
  parameter int TICK_DIV       = 1,
  parameter int GEN_W          = 16,
  parameter int STOP_ON_STABLE = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load,
  input  logic [ROWS*COLS-1:0]               init,
  input  logic                               step,
  input  logic                               run,
  output logic [ROWS*COLS-1:0]               state,
  output logic [GEN_W-1:0]                   gen_count,
  output logic [$clog2(ROWS*COLS+1)-1:0]     pop_count,
  output logic                               stable,
  output logic                               osc,
  output logic                               busy
);

  localparam int N  = ROWS * COLS;
  localparam int PW = $clog2(N + 1);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [N-1:0]  nxt;
  logic [PW-1:0] pop_n;
  logic [DW-1:0] div, div_n;
  fsm_t          fsm, fsm_n;
  logic          same, osc_hit;
  logic          apply, stable_set, osc_set;

  // Edge handling lives here so the cell stays a pure rule evaluator.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [7:0] nbr;
      for (genvar k = 0; k < 9; k++) begin : g_nbr
        if (k != 4) begin : g_use
          localparam int RR = r + k / 3 - 1;
          localparam int CC = c + k % 3 - 1;
          localparam int B  = (k < 4) ? k : k - 1;
          if (WRAP != 0) begin : g_wrap
            assign nbr[B] = state[idx((RR + ROWS) % ROWS, (CC + COLS) % COLS, COLS)];
          end else if (RR >= 0 && RR < ROWS && CC >= 0 && CC < COLS) begin : g_in
            assign nbr[B] = state[idx(RR, CC, COLS)];
          end else begin : g_out
            assign nbr[B] = 1'b0;
          end
        end
      end
      life_cell u_cell (
        .nbr  (nbr),
        .own  (state[idx(r, c, COLS)]),
        .next (nxt[idx(r, c, COLS)])
      );
    end
  end

  assign same = (nxt == state);

`ifdef LIFE_OSC_DETECT_EN
  logic [N-1:0] prev;

  assign osc_hit = (nxt == prev) && !same;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      prev <= '0;
    end else if (apply) begin
      prev <= state;
    end
  end
`else
  assign osc_hit = 1'b0;
`endif

  always_comb begin
    pop_n = '0;
    for (int i = 0; i < N; i++) begin
      pop_n = pop_n + PW'(state[i]);
    end
  end

  always_comb begin
    fsm_n      = fsm;
    div_n      = div;
    apply      = 1'b0;
    stable_set = 1'b0;
    osc_set    = 1'b0;
    case (fsm)
      IDLE: begin
        if (run) begin
          fsm_n = RUN;
          div_n = '0;
        end else if (step) begin
          apply      = 1'b1;
          stable_set = same;
          osc_set    = osc_hit;
        end
      end
      RUN: begin
        if (!run) begin
          fsm_n = IDLE;
          div_n = '0;
        end else if (div == DIV_LAST) begin
          div_n = '0;
          // A still grid halts without being rewritten; an oscillator is applied first.
          if ((STOP_ON_STABLE != 0) && same) begin
            stable_set = 1'b1;
            fsm_n      = HALT;
          end else begin
            apply      = 1'b1;
            stable_set = same;
            osc_set    = osc_hit;
            if ((STOP_ON_STABLE != 0) && osc_hit) begin
              fsm_n = HALT;
            end
          end
        end else begin
          div_n = div + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= '0;
      gen_count <= '0;
      pop_count <= '0;
      stable    <= 1'b0;
      osc       <= 1'b0;
      fsm       <= IDLE;
      div       <= '0;
    end else begin
      pop_count <= pop_n;
      if (load) begin
        state     <= init;
        gen_count <= '0;
        stable    <= 1'b0;
        osc       <= 1'b0;
        fsm       <= IDLE;
        div       <= '0;
      end else begin
        fsm <= fsm_n;
        div <= div_n;
        if (apply) begin
          state <= nxt;
          if (gen_count != '1) begin
            gen_count <= gen_count + 1'b1;
          end
        end
        if (stable_set) begin
          stable <= 1'b1;
        end
        if (osc_set) begin
          osc <= 1'b1;
        end
      end
    end
  end

  assign busy = (fsm == RUN);

endmodule

// File: tb/tb_life_grid_engine.sv
// tb/tb_life_grid_engine.sv - self-checking bench over four engine configurations
module tb_life_grid_engine;

`ifdef LIFE_OSC_DETECT_EN
  localparam logic OSC_EN = 1'b1;
`else
  localparam logic OSC_EN = 1'b0;
`endif

  localparam logic [63:0] VB  = 64'h0000_0000_0002_1080;
  localparam logic [63:0] HB  = 64'h0000_0000_0000_3800;
  localparam logic [63:0] BLK = 64'h0000_0000_0000_18C0;
  localparam logic [63:0] GL  = 64'h0000_0000_0007_0402;
  localparam logic [63:0] GL4 = 64'h0000_0000_0E08_0400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  rst_v, load_v, step_v, run_v;
  logic [63:0] init_w;
  logic [24:0] st_a, st_c, st_d;
  logic [63:0] st_b;
  logic [15:0] gen_a, gen_b, gen_c;
  logic [3:0]  gen_d;
  logic [4:0]  pop_a, pop_c, pop_d;
  logic [6:0]  pop_b;
  logic [3:0]  stb_v, osc_v, busy_v;

  logic [63:0] st_w  [4];
  logic [15:0] gen_w [4];
  logic [6:0]  pop_w [4];

  assign st_w[0]  = {39'd0, st_a};
  assign st_w[1]  = st_b;
  assign st_w[2]  = {39'd0, st_c};
  assign st_w[3]  = {39'd0, st_d};
  assign gen_w[0] = gen_a;
  assign gen_w[1] = gen_b;
  assign gen_w[2] = gen_c;
  assign gen_w[3] = {12'd0, gen_d};
  assign pop_w[0] = {2'd0, pop_a};
  assign pop_w[1] = pop_b;
  assign pop_w[2] = {2'd0, pop_c};
  assign pop_w[3] = {2'd0, pop_d};

  life_grid_engine #(.ROWS(5), .COLS(5), .WRAP(0), .TICK_DIV(1), .GEN_W(16), .STOP_ON_STABLE(1)) dut_a (
    .clk(clk), .rst(rst_v[0]), .load(load_v[0]), .init(init_w[24:0]), .step(step_v[0]), .run(run_v[0]),
    .state(st_a), .gen_count(gen_a), .pop_count(pop_a), .stable(stb_v[0]), .osc(osc_v[0]), .busy(busy_v[0]));

  life_grid_engine #(.ROWS(8), .COLS(8), .WRAP(1), .TICK_DIV(1), .GEN_W(16), .STOP_ON_STABLE(1)) dut_b (
    .clk(clk), .rst(rst_v[1]), .load(load_v[1]), .init(init_w), .step(step_v[1]), .run(run_v[1]),
    .state(st_b), .gen_count(gen_b), .pop_count(pop_b), .stable(stb_v[1]), .osc(osc_v[1]), .busy(busy_v[1]));

  life_grid_engine #(.ROWS(5), .COLS(5), .WRAP(0), .TICK_DIV(4), .GEN_W(16), .STOP_ON_STABLE(0)) dut_c (
    .clk(clk), .rst(rst_v[2]), .load(load_v[2]), .init(init_w[24:0]), .step(step_v[2]), .run(run_v[2]),
    .state(st_c), .gen_count(gen_c), .pop_count(pop_c), .stable(stb_v[2]), .osc(osc_v[2]), .busy(busy_v[2]));

  life_grid_engine #(.ROWS(5), .COLS(5), .WRAP(0), .TICK_DIV(1), .GEN_W(4), .STOP_ON_STABLE(0)) dut_d (
    .clk(clk), .rst(rst_v[3]), .load(load_v[3]), .init(init_w[24:0]), .step(step_v[3]), .run(run_v[3]),
    .state(st_d), .gen_count(gen_d), .pop_count(pop_d), .stable(stb_v[3]), .osc(osc_v[3]), .busy(busy_v[3]));

  typedef struct {
    int          sel;
    logic        chk_st;
    logic [63:0] st;
    logic [15:0] gen;
    logic        chk_pop;
    logic [6:0]  pop;
    logic        sb;
    logic        chk_osc;
    logic        o;
    logic        b;
  } exp_t;

  typedef struct {
    logic        r, l, s, u;
    logic [63:0] ini;
    logic [63:0] st;
    logic [15:0] gen;
    logic [6:0]  pop;
    logic        sb, o, b;
  } vec_t;

  exp_t  exp_q [$];
  string nm_q  [$];
  int    pass_n = 0;
  int    total_n = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
    total_n++;
    if (act === req) pass_n++;
    else $display("FAIL %s: got %h expected %h", nm, act, req);
  endtask

  task automatic drive(input int sel, input logic r, input logic l, input logic s, input logic u,
                       input logic [63:0] ini);
    rst_v  = '0;
    load_v = '0;
    step_v = '0;
    run_v  = '0;
    rst_v[sel]  = r;
    load_v[sel] = l;
    step_v[sel] = s;
    run_v[sel]  = u;
    init_w = ini;
  endtask

  task automatic check_out();
    exp_t  e;
    string nm;
    e  = exp_q.pop_front();
    nm = nm_q.pop_front();
    if (e.chk_st) cmp({nm, ".state"}, st_w[e.sel], e.st);
    cmp({nm, ".gen_count"}, {48'd0, gen_w[e.sel]}, {48'd0, e.gen});
    if (e.chk_pop) cmp({nm, ".pop_count"}, {57'd0, pop_w[e.sel]}, {57'd0, e.pop});
    cmp({nm, ".stable"}, {63'd0, stb_v[e.sel]}, {63'd0, e.sb});
    if (e.chk_osc) cmp({nm, ".osc"}, {63'd0, osc_v[e.sel]}, {63'd0, e.o});
    cmp({nm, ".busy"}, {63'd0, busy_v[e.sel]}, {63'd0, e.b});
  endtask

  // Drive one cycle, queue what the DUT must show after the edge, then compare.
  task automatic cyc(input int sel, input logic r, input logic l, input logic s, input logic u,
                     input logic [63:0] ini, input logic cst, input logic [63:0] st, input logic [15:0] g,
                     input logic cp, input logic [6:0] p, input logic sb, input logic co, input logic o,
                     input logic b, input string nm);
    exp_t e;
    drive(sel, r, l, s, u, ini);
    e = '{sel, cst, st, g, cp, p, sb, co, o, b};
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
    check_out();
  endtask

  vec_t tv [18];

  initial begin
    tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 16'd0, 7'd0, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, VB,    VB,    16'd0, 7'd0, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 64'd0, VB,    16'd0, 7'd3, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 64'd0, HB,    16'd1, 7'd3, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 64'd0, HB,    16'd1, 7'd3, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 64'd0, VB,    16'd2, 7'd3, 1'b0, OSC_EN, 1'b0};
    tv[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 64'd0, VB,    16'd2, 7'd3, 1'b0, OSC_EN, 1'b0};
    tv[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, BLK,   BLK,   16'd0, 7'd3, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 64'd0, BLK,   16'd0, 7'd4, 1'b0, 1'b0, 1'b1};
    tv[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 64'd0, BLK,   16'd0, 7'd4, 1'b1, 1'b0, 1'b0};
    tv[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 64'd0, BLK,   16'd0, 7'd4, 1'b1, 1'b0, 1'b0};
    tv[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 64'd0, BLK,   16'd0, 7'd4, 1'b1, 1'b0, 1'b0};
    tv[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 16'd0, 7'd0, 1'b0, 1'b0, 1'b0};
    tv[13] = '{1'b0, 1'b1, 1'b1, 1'b0, VB,    VB,    16'd0, 7'd0, 1'b0, 1'b0, 1'b0};
    tv[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 64'd0, VB,    16'd0, 7'd3, 1'b0, 1'b0, 1'b0};
    tv[15] = '{1'b0, 1'b1, 1'b0, 1'b1, BLK,   BLK,   16'd0, 7'd3, 1'b0, 1'b0, 1'b0};
    tv[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 64'd0, BLK,   16'd0, 7'd4, 1'b0, 1'b0, 1'b1};
    tv[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 64'd0, BLK,   16'd0, 7'd4, 1'b0, 1'b0, 1'b0};

    rst_v = '1; load_v = '0; step_v = '0; run_v = '0; init_w = '0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      exp_q.push_back('{d, 1'b1, 64'd0, 16'd0, 1'b1, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0});
      nm_q.push_back($sformatf("reset%0d", d));
      check_out();
    end

    // Blinker stepping, still-life halt, reset and load priority on the 5x5 dead-border grid.
    for (int i = 0; i < 18; i++) begin
      cyc(0, tv[i].r, tv[i].l, tv[i].s, tv[i].u, tv[i].ini, 1'b1, tv[i].st, tv[i].gen,
          1'b1, tv[i].pop, tv[i].sb, 1'b1, tv[i].o, tv[i].b, $sformatf("vec%0d", i));
    end

    // Glider on the 8x8 torus returns home after 32 generations.
    cyc(1, 1'b0, 1'b1, 1'b0, 1'b0, GL, 1'b1, GL, 16'd0, 1'b1, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, "gl_load");
    for (int a = 1; a <= 33; a++) begin
      cyc(1, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, (a == 5) || (a == 33), (a == 5) ? GL4 : GL,
          16'(a - 1), 1'b1, 7'd5, 1'b0, 1'b1, 1'b0, 1'b1, $sformatf("gl_run%0d", a));
    end
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, GL, 16'd32, 1'b1, 7'd5, 1'b0, 1'b1, 1'b0, 1'b0, "gl_stop");

    // Tick divider of 4: one generation per four RUN cycles, cleared when run drops.
    cyc(2, 1'b0, 1'b1, 1'b0, 1'b0, VB, 1'b1, VB, 16'd0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, "div_load");
    for (int a = 1; a <= 15; a++) begin
      cyc(2, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 1'b1, ((((a - 1) / 4) % 2) == 1) ? HB : VB,
          16'((a - 1) / 4), 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, $sformatf("div_run%0d", a));
    end
    cyc(2, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, HB, 16'd3, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, "div_idle");
    for (int a = 1; a <= 7; a++) begin
      cyc(2, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 1'b1, (a >= 5) ? VB : HB, (a >= 5) ? 16'd4 : 16'd3,
          1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, $sformatf("div_rerun%0d", a));
    end
    cyc(2, 1'b1, 1'b0, 1'b0, 1'b1, 64'd0, 1'b1, 64'd0, 16'd0, 1'b1, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, "div_rst");
    cyc(2, 1'b0, 1'b1, 1'b1, 1'b0, VB, 1'b1, VB, 16'd0, 1'b1, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, "div_reload");
    for (int a = 1; a <= 5; a++) begin
      cyc(2, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 1'b1, (a == 5) ? HB : VB, (a == 5) ? 16'd1 : 16'd0,
          1'b1, 7'd3, 1'b0, 1'b0, 1'b0, 1'b1, $sformatf("div_after_rst%0d", a));
    end

    // 4-bit generation counter saturates while the grid keeps evolving.
    cyc(3, 1'b0, 1'b1, 1'b0, 1'b0, VB, 1'b1, VB, 16'd0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, "sat_load");
    for (int a = 1; a <= 21; a++) begin
      cyc(3, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 1'b1, (((a - 1) % 2) == 1) ? HB : VB,
          (a - 1 > 15) ? 16'd15 : 16'(a - 1), 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1,
          $sformatf("sat_run%0d", a));
    end

    // Blinker in RUN with auto-halt: halts on the period-2 repeat only when detection is built.
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 64'd0, 16'd0, 1'b1, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, "osc_rst");
    cyc(0, 1'b0, 1'b1, 1'b0, 1'b0, VB, 1'b1, VB, 16'd0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, "osc_load");
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 1'b1, VB, 16'd0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b1, "osc_run1");
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 1'b1, HB, 16'd1, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b1, "osc_run2");
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 1'b1, VB, 16'd2, 1'b0, 7'd0, 1'b0, 1'b1, OSC_EN, !OSC_EN, "osc_run3");
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 1'b1, OSC_EN ? VB : HB, OSC_EN ? 16'd2 : 16'd3,
        1'b0, 7'd0, 1'b0, 1'b1, OSC_EN, !OSC_EN, "osc_run4");

    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
